// File: rtl/combo_result_buffer.sv
// Result queue between an ALU combo and the common data bus: buffers completed
// results, requests the bus while non-empty and emits one entry per grant.
module combo_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RRN_WIDTH  = 6,
    parameter int ARN_WIDTH  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_result,
    input  logic [RRN_WIDTH-1:0]    i_rrn,
    input  logic [ARN_WIDTH-1:0]    i_arn,
    output logic                    o_ready,
    output logic                    o_get_bus,
    input  logic                    i_bus_granted,
    output logic                    o_cdb_valid,
    output logic [DATA_WIDTH-1:0]   o_cdb_result,
    output logic [RRN_WIDTH-1:0]    o_cdb_rrn,
    output logic [ARN_WIDTH-1:0]    o_cdb_arn,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem_result [DEPTH];
    logic [RRN_WIDTH-1:0]  r_mem_rrn    [DEPTH];
    logic [ARN_WIDTH-1:0]  r_mem_arn    [DEPTH];

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_cdb_valid;
    logic [DATA_WIDTH-1:0] r_cdb_result;
    logic [RRN_WIDTH-1:0]  r_cdb_rrn;
    logic [ARN_WIDTH-1:0]  r_cdb_arn;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Handshake: an entry transfers when i_valid && o_ready on a rising edge
    // (flush suppresses it); o_ready depends only on occupancy, so a pop in the
    // same cycle never frees a slot for a push while full.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_valid && !w_full && !i_flush;
    assign w_pop   = i_bus_granted && !w_empty && !i_flush;

    assign o_ready      = !w_full;
    assign o_full       = w_full;
    assign o_get_bus    = !w_empty && !i_flush;
    assign o_count      = r_count;
    assign o_cdb_valid  = r_cdb_valid;
    assign o_cdb_result = r_cdb_result;
    assign o_cdb_rrn    = r_cdb_rrn;
    assign o_cdb_arn    = r_cdb_arn;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= i_result;
            r_mem_rrn[r_wr_ptr]    <= i_rrn;
            r_mem_arn[r_wr_ptr]    <= i_arn;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_result <= '0;
            r_cdb_rrn    <= '0;
            r_cdb_arn    <= '0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
                r_cdb_result <= r_mem_result[r_rd_ptr];
                r_cdb_rrn    <= r_mem_rrn[r_rd_ptr];
                r_cdb_arn    <= r_mem_arn[r_rd_ptr];
            end
            // Payload registers hold their last value when no pop occurs.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_combo_result_buffer.sv
// Bench for combo_result_buffer: fixed vector table, hand-written corner
// sequences and random traffic checked against a queue-based model.
module tb_combo_result_buffer;

    localparam int DEPTH = 4;
    localparam int EW    = 32 + 6 + 5;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_result = '0;
    logic [5:0]  i_rrn = '0;
    logic [4:0]  i_arn = '0;
    logic        o_ready;
    logic        o_get_bus;
    logic        i_bus_granted = 1'b0;
    logic        o_cdb_valid;
    logic [31:0] o_cdb_result;
    logic [5:0]  o_cdb_rrn;
    logic [4:0]  o_cdb_arn;
    logic        o_full;
    logic [2:0]  o_count;

    combo_result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(32), .RRN_WIDTH(6), .ARN_WIDTH(5)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid),
        .i_result(i_result), .i_rrn(i_rrn), .i_arn(i_arn), .o_ready(o_ready),
        .o_get_bus(o_get_bus), .i_bus_granted(i_bus_granted), .o_cdb_valid(o_cdb_valid),
        .o_cdb_result(o_cdb_result), .o_cdb_rrn(o_cdb_rrn), .o_cdb_arn(o_cdb_arn),
        .o_full(o_full), .o_count(o_count)
    );

    // clock
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: queue of packed {result, rrn, arn}
    logic [EW-1:0] exp_q[$];
    logic          m_cv;
    logic [EW-1:0] m_cdb;
    logic          m_ready_pre, m_get_pre;
    logic          s_ready_pre, s_get_pre;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cv  = 1'b0;
        m_cdb = '0;
    endtask

    // Drive one cycle of inputs, sample combinational outputs mid-cycle,
    // advance the model across the edge, and leave time at edge+1.
    task automatic drive_cycle(input logic v, input logic f, input logic g,
                               input logic [31:0] res, input logic [5:0] rrn, input logic [4:0] arn);
        logic do_push;
        i_valid = v; i_flush = f; i_bus_granted = g;
        i_result = res; i_rrn = rrn; i_arn = arn;
        #1;
        s_ready_pre = o_ready;
        s_get_pre   = o_get_bus;
        m_ready_pre = (exp_q.size() < DEPTH);
        m_get_pre   = (exp_q.size() != 0) && !f;
        do_push     = v && (exp_q.size() < DEPTH);
        @(posedge i_clk);
        #1;
        if (f) begin
            exp_q.delete();
            m_cv = 1'b0;
        end else begin
            if (g && exp_q.size() != 0) begin
                m_cv  = 1'b1;
                m_cdb = exp_q.pop_front();
            end else begin
                m_cv = 1'b0;
            end
            if (do_push) exp_q.push_back({res, rrn, arn});
        end
    endtask

    task automatic idle_cycle(input logic g);
        drive_cycle(1'b0, 1'b0, g, 32'h0, 6'h0, 5'h0);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ready"},  {63'h0, s_ready_pre}, {63'h0, m_ready_pre});
        check({tag, ".getbus"}, {63'h0, s_get_pre},   {63'h0, m_get_pre});
        check({tag, ".cdbv"},   {63'h0, o_cdb_valid}, {63'h0, m_cv});
        check({tag, ".cdbpay"}, {21'h0, o_cdb_result, o_cdb_rrn, o_cdb_arn}, {21'h0, m_cdb});
        check({tag, ".count"},  {61'h0, o_count}, 64'(exp_q.size()));
        check({tag, ".full"},   {63'h0, o_full},  {63'h0, exp_q.size() == DEPTH});
    endtask

    typedef struct {
        logic        v, g;
        logic [31:0] res;
        logic [5:0]  rrn;
        logic [4:0]  arn;
        logic        e_ready, e_get, e_cv;
        logic [31:0] e_res;
        logic [5:0]  e_rrn;
        logic [4:0]  e_arn;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // hand-derived vectors: single transfer, spurious grant, fill/overflow, drain
        vecs[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 6'd5, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 5'd0, 3'd1};
        vecs[1]  = '{1'b0, 1'b1, 32'h0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 6'd5, 5'd3, 3'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 5'd0, 3'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'hA0000001, 6'd1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 5'd0, 3'd1};
        vecs[4]  = '{1'b1, 1'b0, 32'hA0000002, 6'd2, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 5'd0, 3'd2};
        vecs[5]  = '{1'b1, 1'b0, 32'hA0000003, 6'd3, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 5'd0, 3'd3};
        vecs[6]  = '{1'b1, 1'b0, 32'hA0000004, 6'd4, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 5'd0, 3'd4};
        vecs[7]  = '{1'b1, 1'b0, 32'hA0000005, 6'd5, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0, 6'd0, 5'd0, 3'd4};
        vecs[8]  = '{1'b1, 1'b1, 32'hA0000006, 6'd6, 5'd6, 1'b0, 1'b1, 1'b1, 32'hA0000001, 6'd1, 5'd1, 3'd3};
        vecs[9]  = '{1'b0, 1'b1, 32'h0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hA0000002, 6'd2, 5'd2, 3'd2};
        vecs[10] = '{1'b1, 1'b1, 32'hB0000001, 6'd7, 5'd7, 1'b1, 1'b1, 1'b1, 32'hA0000003, 6'd3, 5'd3, 3'd2};
        vecs[11] = '{1'b0, 1'b1, 32'h0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hA0000004, 6'd4, 5'd4, 3'd1};
        vecs[12] = '{1'b0, 1'b1, 32'h0, 6'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hB0000001, 6'd7, 5'd7, 3'd0};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 5'd0, 3'd0};

        // reset
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst.cdbv",   {63'h0, o_cdb_valid}, 64'h0);
        check("rst.cdbres", {32'h0, o_cdb_result}, 64'h0);
        check("rst.ready",  {63'h0, o_ready}, 64'h1);
        check("rst.getbus", {63'h0, o_get_bus}, 64'h0);
        check("rst.full",   {63'h0, o_full}, 64'h0);
        check("rst.count",  {61'h0, o_count}, 64'h0);
        #2 i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // table vectors
        for (int i = 0; i < 14; i++) begin
            drive_cycle(vecs[i].v, 1'b0, vecs[i].g, vecs[i].res, vecs[i].rrn, vecs[i].arn);
            check($sformatf("vec%0d.ready", i),  {63'h0, s_ready_pre}, {63'h0, vecs[i].e_ready});
            check($sformatf("vec%0d.getbus", i), {63'h0, s_get_pre},   {63'h0, vecs[i].e_get});
            check($sformatf("vec%0d.cdbv", i),   {63'h0, o_cdb_valid}, {63'h0, vecs[i].e_cv});
            check($sformatf("vec%0d.count", i),  {61'h0, o_count},     {61'h0, vecs[i].e_cnt});
            check($sformatf("vec%0d.full", i),   {63'h0, o_full},      {63'h0, vecs[i].e_cnt == 3'd4});
            if (vecs[i].e_cv)
                check($sformatf("vec%0d.payload", i), {21'h0, o_cdb_result, o_cdb_rrn, o_cdb_arn},
                      {21'h0, vecs[i].e_res, vecs[i].e_rrn, vecs[i].e_arn});
        end

        // simultaneous push+pop at count 2, 8 times across pointer wrap
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hC0000000, 6'd10, 5'd10); check_model("sim.fill0");
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hC0000001, 6'd11, 5'd11); check_model("sim.fill1");
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 32'hC0000002 + 32'(k), 6'(12 + k), 5'(12 + k));
            check_model($sformatf("sim%0d", k));
            check($sformatf("sim%0d.cnt2", k), {61'h0, o_count}, 64'd2);
            check($sformatf("sim%0d.oldest", k), {32'h0, o_cdb_result}, {32'h0, 32'hC0000000 + 32'(k)});
        end
        idle_cycle(1'b1); check_model("sim.drain0");
        idle_cycle(1'b1); check_model("sim.drain1");

        // grant withheld for 10 cycles after a pop: request held, payload unchanged
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h12345678, 6'd33, 5'd17); check_model("hold.push");
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h0BADF00D, 6'd34, 5'd18); check_model("hold.pop");
        for (int k = 0; k < 10; k++) begin
            idle_cycle(1'b0);
            check_model($sformatf("hold%0d", k));
            check($sformatf("hold%0d.getbus", k), {63'h0, s_get_pre}, 64'h1);
        end
        idle_cycle(1'b1); check_model("hold.grant");
        check("hold.last", {32'h0, o_cdb_result}, {32'h0, 32'h0BADF00D});

        // flush at count 3 with valid and grant active
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'hF0000000 + 32'(k), 6'(40 + k), 5'(20 + k));
            check_model($sformatf("fl.push%0d", k));
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 6'd63, 5'd31);
        check_model("fl.flush");
        check("fl.count0", {61'h0, o_count}, 64'h0);
        check("fl.getbus_in_flush", {63'h0, s_get_pre}, 64'h0);
        for (int k = 0; k < 4; k++) begin
            idle_cycle(1'b1);
            check_model($sformatf("fl.after%0d", k));
        end

        // asynchronous reset mid-stream while a result is on the bus
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h55550000, 6'd1, 5'd1); check_model("ar.push0");
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h55550001, 6'd2, 5'd2); check_model("ar.push1");
        idle_cycle(1'b1); check_model("ar.pop");
        #2 i_reset_n = 1'b0;
        #1;
        check("ar.cdbv",  {63'h0, o_cdb_valid}, 64'h0);
        check("ar.ready", {63'h0, o_ready}, 64'h1);
        check("ar.count", {61'h0, o_count}, 64'h0);
        model_reset();
        @(posedge i_clk);
        #2 i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
                        $urandom_range(0, 99) < 50, $urandom, 6'($urandom), 5'($urandom));
            check_model($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
